// File: rtl/cache_axi_master.sv
// AXI4 burst master for D-cache line refills (INCR read) and dirty-line writebacks (INCR write).
// One transaction in flight; a writeback wins over a refill requested in the same cycle.
module cache_axi_master #(
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rf_req,
  input  logic [ADDR_W-1:0]        rf_addr,
  output logic [64*LINE_BEATS-1:0] rf_line,
  output logic                     rf_done,
  input  logic                     wb_req,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [64*LINE_BEATS-1:0] wb_line,
  output logic                     wb_done,
  output logic                     bus_err,
  output logic                     busy,
  output logic [ADDR_W-1:0]        araddr,
  output logic                     arvalid,
  output logic [1:0]               arburst,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  input  logic                     arready,
  input  logic [63:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  input  logic                     rlast,
  output logic                     rready,
  output logic [ADDR_W-1:0]        awaddr,
  output logic                     awvalid,
  output logic [1:0]               awburst,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  input  logic                     awready,
  output logic [63:0]              wdata,
  output logic [7:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int unsigned OffW = $clog2(8 * LINE_BEATS);
  localparam int unsigned CntW = $clog2(LINE_BEATS) + 1;
  localparam int unsigned IdxW = CntW - 1;

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                is_wr_q, is_wr_d;
  logic [63:0]         wbeat_q [LINE_BEATS];
  logic [63:0]         wbeat_d [LINE_BEATS];
  logic [63:0]         rbeat_q [LINE_BEATS];
  logic [63:0]         rbeat_d [LINE_BEATS];

  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arsize  = 3'd3;
  assign awsize  = 3'd3;
  assign arlen   = 8'(LINE_BEATS - 1);
  assign awlen   = 8'(LINE_BEATS - 1);
  assign wstrb   = 8'hFF;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign busy    = (state_q != StIdle);
  assign wdata   = wbeat_q[cnt_q[IdxW-1:0]];

  // Saturate so a runaway read burst can never alias back onto slot 0.
  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    for (int i = 0; i < LINE_BEATS; i++) rf_line[64*i +: 64] = rbeat_q[i];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    is_wr_d = is_wr_q;
    wbeat_d = wbeat_q;
    rbeat_d = rbeat_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    rf_done = 1'b0;
    wb_done = 1'b0;
    bus_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wb_req) begin
          addr_d  = {wb_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
          for (int i = 0; i < LINE_BEATS; i++) wbeat_d[i] = wb_line[64*i +: 64];
          is_wr_d = 1'b1;
          state_d = StAw;
        end else if (rf_req) begin
          addr_d  = {rf_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
          is_wr_d = 1'b0;
          state_d = StAr;
        end
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) begin
          cnt_d   = '0;
          state_d = StR;
        end
      end
      StR: begin
        rready = 1'b1;
        if (rvalid) begin
          if (cnt_q < CntW'(LINE_BEATS)) rbeat_d[cnt_q[IdxW-1:0]] = rdata;
          else err_d = 1'b1;
          if (rresp != 2'b00) err_d = 1'b1;
          if (rlast && (cnt_q != CntW'(LINE_BEATS - 1))) err_d = 1'b1;
          cnt_d = cnt_inc;
          if (rlast) state_d = StDone;
        end
      end
      StAw: begin
        awvalid = 1'b1;
        if (awready) begin
          cnt_d   = '0;
          state_d = StW;
        end
      end
      StW: begin
        wvalid = 1'b1;
        wlast  = (cnt_q == CntW'(LINE_BEATS - 1));
        if (wready) begin
          cnt_d = cnt_inc;
          if (wlast) state_d = StB;
        end
      end
      StB: begin
        bready = 1'b1;
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        rf_done = ~is_wr_q;
        wb_done = is_wr_q;
        bus_err = err_q;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      is_wr_q <= 1'b0;
      for (int i = 0; i < LINE_BEATS; i++) begin
        wbeat_q[i] <= '0;
        rbeat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      is_wr_q <= is_wr_d;
      wbeat_q <= wbeat_d;
      rbeat_q <= rbeat_d;
    end
  end

endmodule
